// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: coin values, price and dispenser states.
package vending_pkg;

  localparam int PRICE_CENTS   = 20;
  localparam int NICKLE_CENTS  = 5;
  localparam int DIME_CENTS    = 10;
  localparam int QUARTER_CENTS = 25;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } dispense_state_e;

endpackage

// File: rtl/dispensing_purchase_buffer.sv
// One-deep holding register for a purchase that arrives while the dispenser is busy.
// A push in the same cycle as a pop replaces the entry; a push into a full buffer
// without a pop is dropped and latches the sticky overflow flag.
module purchase_buffer #(
  parameter int W = 6
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic [W-1:0] data_o,
  output logic         overflow_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         ovf_q, ovf_d;

  // Next-state for the entry and the sticky drop flag.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (pop_i) begin
      valid_d = 1'b0;
    end
    if (push_i) begin
      if (!valid_q || pop_i) begin
        valid_d = 1'b1;
        data_d  = data_i;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Buffer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign full_o     = valid_q;
  assign data_o     = data_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/dispensing.sv
// Vend side of the vending machine: releases the product when the deposit reaches
// the price, then pays the change out through the hopper, dimes before nickels.
module dispensing
  import vending_pkg::*;
#(
  parameter int PRICE = PRICE_CENTS,
  parameter int W     = 6
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] deposit_i,
  input  logic         hopper_ready_i,
  output logic         soda_o,
  output logic         dime_o,
  output logic         nickle_o,
  output logic [W-1:0] change_o,
  output logic         busy_o,
  output logic         overflow_o
);

  localparam logic [W-1:0] PriceW  = W'(PRICE);
  localparam logic [W-1:0] NickleW = W'(NICKLE_CENTS);
  localparam logic [W-1:0] DimeW   = W'(DIME_CENTS);

  dispense_state_e state_q, state_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    change_q, change_d;

  logic         trigger;
  logic [W-1:0] trig_amount;
  logic         buf_push, buf_pop, buf_full;
  logic [W-1:0] buf_data;
  logic         soda, dime, nickle;

  assign trigger     = (deposit_i >= PriceW);
  assign trig_amount = deposit_i - PriceW;

  purchase_buffer #(.W(W)) u_buf (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (buf_push),
    .pop_i      (buf_pop),
    .data_i     (trig_amount),
    .full_o     (buf_full),
    .data_o     (buf_data),
    .overflow_o (overflow_o)
  );

  // Next state, change bookkeeping and the one-hot vend/coin outputs.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    change_d = change_q;
    buf_push = 1'b0;
    buf_pop  = 1'b0;
    soda     = 1'b0;
    dime     = 1'b0;
    nickle   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (buf_full) begin
          // Deferred purchase goes first; a new trigger now takes its buffer slot.
          buf_pop  = 1'b1;
          buf_push = trigger;
          rem_d    = buf_data;
          change_d = buf_data;
          state_d  = VEND;
        end else if (trigger) begin
          rem_d    = trig_amount;
          change_d = trig_amount;
          state_d  = VEND;
        end
      end
      VEND: begin
        soda     = 1'b1;
        buf_push = trigger;
        state_d  = (rem_q >= NickleW) ? CHANGE : IDLE;
      end
      CHANGE: begin
        buf_push = trigger;
        if (rem_q >= DimeW) begin
          dime = hopper_ready_i;
          if (hopper_ready_i) rem_d = rem_q - DimeW;
        end else if (rem_q >= NickleW) begin
          nickle = hopper_ready_i;
          if (hopper_ready_i) rem_d = rem_q - NickleW;
        end
        // Anything under a nickel cannot be paid and is abandoned.
        if (rem_d < NickleW) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, remaining-change and reported-change registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      change_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      change_q <= change_d;
    end
  end

  assign soda_o   = soda;
  assign dime_o   = dime;
  assign nickle_o = nickle;
  assign change_o = change_q;
  assign busy_o   = (state_q != IDLE);

endmodule

// File: doc/dispensing.md
# dispensing

Vend-side counterpart of the coin acceptor in the vending-machine datapath. It watches the acceptor's registered `deposit` total and detects a purchase whenever that total reaches the price. On each purchase it pulses the product-release line for one cycle. It then pays out change (deposit − price) one coin at a time, dimes first and nickels second, through a ready-gated coin hopper. A one-deep pending buffer absorbs a second purchase that arrives while change is still being paid.

## Interface
- `PRICE` — default 20 — product price in cents; must be a multiple of 5.
- `W` — default 6 — width of the deposit and change values in cents.
- `clk_i` input 1 — single clock; all state updates on the rising edge.
- `rst_ni` input 1 — asynchronous, active-low reset.
- `deposit_i` input W — running deposit from the coin acceptor.
  - Holds a value ≥ PRICE for exactly one cycle per purchase.
- `hopper_ready_i` input 1 — the coin hopper can accept a coin-eject pulse this cycle.
- `soda_o` output 1 — one-cycle product-release pulse.
- `dime_o` output 1 — eject one dime this cycle.
- `nickle_o` output 1 — eject one nickel this cycle.
- `change_o` output W — total change for the current purchase; held until the next purchase starts.
- `busy_o` output 1 — high whenever state ≠ IDLE.
- `overflow_o` output 1 — sticky flag: a purchase was dropped because the pending buffer was full.

## Operation
- **Trigger:** `deposit_i ≥ PRICE`, sampled on a rising edge.
- **Change amount:** `deposit_i − PRICE`, computed at W bits; it never underflows because the trigger guarantees `deposit_i ≥ PRICE`.
- **States:** IDLE, VEND, CHANGE.
- **IDLE:**
  - If the pending buffer is valid, start that purchase: load the remaining-change register `rem` and `change_o` from the buffer, clear the buffer, go to VEND.
  - Otherwise, if the trigger is true, load `rem` and `change_o` with `deposit_i − PRICE` and go to VEND.
  - If the buffer is valid and the trigger is true in the same cycle, the new purchase is written into the buffer.
- **VEND:**
  - `soda_o` = 1 for this single cycle.
  - Next state is CHANGE if `rem` ≥ 5, else IDLE.
- **CHANGE:**
  - `dime_o` = `hopper_ready_i` && `rem` ≥ 10.
  - `nickle_o` = `hopper_ready_i` && 5 ≤ `rem` < 10.
  - On each issued coin, `rem` decreases by 10 or 5.
  - When the post-decrement `rem` is < 5, go to IDLE.
  - A residual below 5 is discarded. This can only happen with a malformed deposit.
- **Busy trigger:** a trigger while state ≠ IDLE is captured into the pending buffer (valid flag plus W-bit amount) if the buffer is empty. If the buffer is full, the purchase is dropped and `overflow_o` is set.
- **Output encoding:** `soda_o`, `dime_o` and `nickle_o` are mutually exclusive by construction.
- **Reset values:** all outputs 0, state IDLE, `rem` 0, pending buffer empty, `overflow_o` cleared. Reset asserted mid-payout abandons the remaining change.

## Timing
- Trigger sampled at edge k → `soda_o` high during cycle k+1 → earliest coin during cycle k+2.
- Change takes one cycle per coin while `hopper_ready_i` stays high.
- `hopper_ready_i` low stalls payout: no coin is issued and `rem` holds.
- A pending purchase reaches VEND one cycle after the return to IDLE, since IDLE lasts one cycle.
- `busy_o` is low for that IDLE cycle.

## Structure
- Shared package `vending_pkg`:
  - Constants `PRICE_CENTS = 20`, `NICKLE_CENTS = 5`, `DIME_CENTS = 10`, `QUARTER_CENTS = 25`.
  - The enum `dispense_state_e` with values IDLE, VEND, CHANGE.
  - The acceptor uses the same coin constants from this package.
- Sub-module `purchase_buffer`: one-deep valid/amount register providing push, pop, full and overflow.

## Test plan
- **Exact price:** `deposit_i` = 20 for one cycle → `soda_o` pulse next cycle, no coins, `change_o` = 0, back to IDLE.
- **Dime plus nickel:** `deposit_i` = 35, hopper always ready → `soda_o`, then `dime_o`, then `nickle_o` on consecutive cycles; `change_o` = 15.
- **Two dimes, stalled:** `deposit_i` = 40 with `hopper_ready_i` low for 3 cycles after VEND → no coins during the stall, then two `dime_o` pulses; `rem` holds at 20 throughout the stall.
- **Pending purchase:** second trigger `deposit_i` = 25 arrives during CHANGE of the first → after the first payout ends, IDLE for 1 cycle, then `soda_o` and one `nickle_o`. A third trigger during that time sets `overflow_o`.
- **Reset mid-payout:** reset asserted during CHANGE with `rem` = 10 → all outputs 0 immediately, no further coins, `overflow_o` cleared.
